alu_muldiv: RTL and testbench

ALU_MULDIV -- requirements
Module: alu_muldiv

---
 rtl/alu_muldiv.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_alu_muldiv.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
// alu_muldiv: sequential multiply/divide unit, one quotient or product bit per cycle.
//   MUL/IMUL: shift-add on operand magnitudes, sign restored at the end.
//   DIV:      restoring divide of {D,A} by B, range-checked up front.
//   IDIV:     signed divide, only when ALU_MULDIV_IDIV_EN is defined; otherwise
//             Operation=11 always finishes as a divide error.
// Operand width n is WIDTH (byteWord=1) or WIDTH/2 (byteWord=0).
//
// state | meaning
// IDLE  | waiting for start; operands captured on acceptance
// PREP  | two cycles: phase 0 takes operand magnitudes, phase 1 range-checks and loads RUN
// RUN   | n iterations, one bit per cycle
// FIX   | sign correction, results and flags written
// DONE  | done pulse, then back to IDLE
module alu_muldiv #(
   parameter int WIDTH = 16
) (
   input  logic             CLK,
   input  logic             RESET_n,
   input  logic             start,
   input  logic [1:0]       Operation,
   input  logic             byteWord,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] D,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] ResultLo,
   output logic [WIDTH-1:0] ResultHi,
   output logic             F_Carry,
   output logic             F_Overflow,
   output logic             F_DivError
);

   localparam int HALF = WIDTH / 2;
   localparam int W2   = 2 * WIDTH;
   localparam int CW   = $clog2(WIDTH);

   localparam logic [1:0] OP_MUL  = 2'b00;
   localparam logic [1:0] OP_IMUL = 2'b01;
   localparam logic [1:0] OP_DIV  = 2'b10;
   localparam logic [1:0] OP_IDIV = 2'b11;

   localparam logic [WIDTH-1:0] ONE_W    = 1;
   localparam logic [W2-1:0]    ONE_2W   = 1;
   localparam logic [CW-1:0]    CNT_ONE  = 1;
   localparam logic [CW-1:0]    CNT_WORD = CW'(WIDTH - 1);
   localparam logic [CW-1:0]    CNT_HALF = CW'(HALF - 1);

   typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} stateT;

   stateT             state;
   logic              prepPhase;
   logic [1:0]        opReg;
   logic              wordMode;
   logic [WIDTH-1:0]  aReg, dReg, bReg;
   logic [W2-1:0]     dvdMag;      // dividend magnitude, or multiplicand magnitude for MUL/IMUL
   logic [WIDTH-1:0]  magB;        // divisor / multiplier magnitude
   logic              negQuo;      // product or quotient must be negated in FIX
   logic [CW-1:0]     cnt;
   logic [W2-1:0]     prodAcc, mcand;
   logic [WIDTH-1:0]  mplier;
   logic [WIDTH-1:0]  remReg, quoReg;
`ifdef ALU_MULDIV_IDIV_EN
   logic              negRem;      // remainder takes the dividend's sign
   logic              signDvd;
   logic [W2-1:0]     absDvd;
   logic [W2-1:0]     limitPos, limitNeg;
`endif

   logic [WIDTH-1:0]  inMask, maskN;
   logic [W2-1:0]     mask2N;
   logic              signA, signB;
   logic [WIDTH-1:0]  absA, absB;
   logic [W2-1:0]     dvdFull, divLimitU;
   logic [WIDTH-1:0]  dvdHi, dvdLoAligned;
   logic              divFail;
   logic [WIDTH:0]    remSh;
   logic              remFits;
   logic [WIDTH-1:0]  remSub;
   logic [W2-1:0]     prodFinal;
   logic [WIDTH-1:0]  prodLo, prodHi;
   logic              prodLoSign, mulOvf;
   logic [WIDTH-1:0]  quoFinal, remFinal;

   // Datapath: magnitudes, range checks, one iteration step and final sign fix-up
   always_comb begin
      inMask   = byteWord ? {WIDTH{1'b1}} : {{HALF{1'b0}}, {HALF{1'b1}}};
      maskN    = wordMode ? {WIDTH{1'b1}} : {{HALF{1'b0}}, {HALF{1'b1}}};
      mask2N   = wordMode ? {W2{1'b1}} : {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
      signA    = wordMode ? aReg[WIDTH-1] : aReg[HALF-1];
      signB    = wordMode ? bReg[WIDTH-1] : bReg[HALF-1];
      absA     = signA ? ((~aReg + ONE_W) & maskN) : aReg;
      absB     = signB ? ((~bReg + ONE_W) & maskN) : bReg;
      dvdFull  = wordMode ? {dReg, aReg}
                          : {{WIDTH{1'b0}}, dReg[HALF-1:0], aReg[HALF-1:0]};

      // Remainder starts as the dividend high half; the low half is left-aligned
      // so its next bit is always at the MSB whatever n is.
      dvdHi        = wordMode ? dvdMag[W2-1:WIDTH] : {{HALF{1'b0}}, dvdMag[WIDTH-1:HALF]};
      dvdLoAligned = wordMode ? dvdMag[WIDTH-1:0] : {dvdMag[HALF-1:0], {HALF{1'b0}}};

      // Unsigned quotient fits in n bits iff dividend < divisor * 2^n
      divLimitU = wordMode ? {magB, {WIDTH{1'b0}}}
                           : {{HALF{1'b0}}, magB, {HALF{1'b0}}};
      divFail   = (magB == '0) || (dvdMag >= divLimitU);
`ifdef ALU_MULDIV_IDIV_EN
      signDvd  = wordMode ? dReg[WIDTH-1] : dReg[HALF-1];
      absDvd   = signDvd ? ((~dvdFull + ONE_2W) & mask2N) : dvdFull;
      // Positive quotient may reach 2^(n-1)-1, negative may reach -2^(n-1)
      limitPos = wordMode ? ({{WIDTH{1'b0}}, magB} << (WIDTH - 1))
                          : ({{WIDTH{1'b0}}, magB} << (HALF - 1));
      limitNeg = limitPos + {{WIDTH{1'b0}}, magB};
      if (opReg == OP_IDIV)
         divFail = (magB == '0) || (dvdMag >= (negQuo ? limitNeg : limitPos));
`else
      if (opReg == OP_IDIV)
         divFail = 1'b1;
`endif

      remSh   = {remReg, quoReg[WIDTH-1]};
      remFits = remSh >= {1'b0, magB};
      remSub  = remSh[WIDTH-1:0] - magB;

      prodFinal  = negQuo ? ((~prodAcc + ONE_2W) & mask2N) : prodAcc;
      prodLo     = wordMode ? prodFinal[WIDTH-1:0] : {{HALF{1'b0}}, prodFinal[HALF-1:0]};
      prodHi     = wordMode ? prodFinal[W2-1:WIDTH] : {{HALF{1'b0}}, prodFinal[WIDTH-1:HALF]};
      prodLoSign = wordMode ? prodLo[WIDTH-1] : prodLo[HALF-1];
      if (opReg == OP_IMUL)
         mulOvf = prodHi != (prodLoSign ? maskN : '0);
      else
         mulOvf = prodHi != '0;

      quoFinal = quoReg;
      remFinal = remReg;
`ifdef ALU_MULDIV_IDIV_EN
      if (opReg == OP_IDIV) begin
         if (negQuo) quoFinal = (~quoReg + ONE_W) & maskN;
         if (negRem) remFinal = (~remReg + ONE_W) & maskN;
      end
`endif
   end

   // Sequencer FSM with registered status and result outputs
   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         state      <= IDLE;
         prepPhase  <= 1'b0;
         opReg      <= '0;
         wordMode   <= 1'b0;
         aReg       <= '0;
         dReg       <= '0;
         bReg       <= '0;
         dvdMag     <= '0;
         magB       <= '0;
         negQuo     <= 1'b0;
         cnt        <= '0;
         prodAcc    <= '0;
         mcand      <= '0;
         mplier     <= '0;
         remReg     <= '0;
         quoReg     <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         ResultLo   <= '0;
         ResultHi   <= '0;
         F_Carry    <= 1'b0;
         F_Overflow <= 1'b0;
         F_DivError <= 1'b0;
`ifdef ALU_MULDIV_IDIV_EN
         negRem     <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  opReg     <= Operation;
                  wordMode  <= byteWord;
                  aReg      <= A & inMask;
                  dReg      <= D & inMask;
                  bReg      <= B & inMask;
                  prepPhase <= 1'b0;
                  busy      <= 1'b1;
                  state     <= PREP;
               end
            end
            PREP: begin
               if (!prepPhase) begin
                  prepPhase <= 1'b1;
                  negQuo    <= 1'b0;
                  magB      <= bReg;
                  case (opReg)
                     OP_MUL:  dvdMag <= {{WIDTH{1'b0}}, aReg};
                     OP_IMUL: begin
                        dvdMag <= {{WIDTH{1'b0}}, absA};
                        magB   <= absB;
                        negQuo <= signA ^ signB;
                     end
                     OP_DIV:  dvdMag <= dvdFull;
                     default: begin
`ifdef ALU_MULDIV_IDIV_EN
                        dvdMag <= absDvd;
                        magB   <= absB;
                        negQuo <= signDvd ^ signB;
                        negRem <= signDvd;
`else
                        dvdMag <= dvdFull;
`endif
                     end
                  endcase
               end else begin
                  prepPhase <= 1'b0;
                  if (opReg[1] && divFail) begin
                     // Results keep their previous values on a divide error
                     F_Carry    <= 1'b0;
                     F_Overflow <= 1'b0;
                     F_DivError <= 1'b1;
                     done       <= 1'b1;
                     state      <= DONE;
                  end else begin
                     prodAcc <= '0;
                     mcand   <= dvdMag;
                     mplier  <= magB;
                     remReg  <= dvdHi;
                     quoReg  <= dvdLoAligned;
                     cnt     <= wordMode ? CNT_WORD : CNT_HALF;
                     state   <= RUN;
                  end
               end
            end
            RUN: begin
               if (opReg[1]) begin
                  if (remFits) begin
                     remReg <= remSub;
                     quoReg <= {quoReg[WIDTH-2:0], 1'b1};
                  end else begin
                     remReg <= remSh[WIDTH-1:0];
                     quoReg <= {quoReg[WIDTH-2:0], 1'b0};
                  end
               end else begin
                  if (mplier[0])
                     prodAcc <= prodAcc + mcand;
                  mcand  <= mcand << 1;
                  mplier <= mplier >> 1;
               end
               if (cnt == '0)
                  state <= FIX;
               else
                  cnt <= cnt - CNT_ONE;
            end
            FIX: begin
               if (opReg[1]) begin
                  ResultLo   <= quoFinal;
                  ResultHi   <= remFinal;
                  F_Carry    <= 1'b0;
                  F_Overflow <= 1'b0;
               end else begin
                  ResultLo   <= prodLo;
                  ResultHi   <= prodHi;
                  F_Carry    <= mulOvf;
                  F_Overflow <= mulOvf;
               end
               F_DivError <= 1'b0;
               done       <= 1'b1;
               state      <= DONE;
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed vectors for alu_muldiv (WIDTH=16), hand-computed expectations.
// Edge numbering: the edge that samples start is edge 0.
module tb_alu_muldiv;

   logic        CLK = 1'b0;
   logic        RESET_n;
   logic        start;
   logic [1:0]  Operation;
   logic        byteWord;
   logic [15:0] A, D, B;
   logic        busy, done;
   logic [15:0] ResultLo, ResultHi;
   logic        F_Carry, F_Overflow, F_DivError;

   int vectors     = 0;
   int miscompares = 0;
   int lat;
   int pulses;

   alu_muldiv #(.WIDTH(16)) dut (
      .CLK(CLK), .RESET_n(RESET_n), .start(start), .Operation(Operation),
      .byteWord(byteWord), .A(A), .D(D), .B(B), .busy(busy), .done(done),
      .ResultLo(ResultLo), .ResultHi(ResultHi), .F_Carry(F_Carry),
      .F_Overflow(F_Overflow), .F_DivError(F_DivError)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one operation, scramble the inputs after acceptance, and return the
   // edge number at which done is seen (0 if it never comes within 40 edges).
   task automatic runOp(input logic [1:0] op, input logic bw, input logic [15:0] a,
                        input logic [15:0] d, input logic [15:0] b, output int latency);
      Operation = op; byteWord = bw; A = a; D = d; B = b; start = 1'b1;
      @(posedge CLK); #1;
      start = 1'b0; A = 16'hA5C3; D = 16'h3C5A; B = 16'h0F0F; byteWord = ~bw;
      latency = 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge CLK); #1;
         if (done) begin
            latency = k;
            break;
         end
      end
   endtask

   initial begin
      RESET_n = 1'b0; start = 1'b0; Operation = 2'b00; byteWord = 1'b1;
      A = '0; D = '0; B = '0;
      #23;
      check("reset_lo", 32'(ResultLo), 32'h0);
      check("reset_hi", 32'(ResultHi), 32'h0);
      check("reset_status", {27'b0, busy, done, F_Carry, F_Overflow, F_DivError}, 32'h0);
      @(negedge CLK); RESET_n = 1'b1;
      @(posedge CLK); #1;

      // MUL word 0x1234 * 0x0100
      runOp(2'b00, 1'b1, 16'h1234, 16'h0000, 16'h0100, lat);
      check("mul_w_lat", 32'(lat), 32'd19);
      check("mul_w_lo", 32'(ResultLo), 32'h3400);
      check("mul_w_hi", 32'(ResultHi), 32'h0012);
      check("mul_w_flags", {29'b0, F_Carry, F_Overflow, F_DivError}, 32'b110);
      check("mul_w_busy", 32'(busy), 32'h1);
      @(posedge CLK); #1;
      check("mul_w_after", {30'b0, busy, done}, 32'b00);

      // IMUL byte -1 * 2
      runOp(2'b01, 1'b0, 16'h00FF, 16'h0000, 16'h0002, lat);
      check("imul_b_lat", 32'(lat), 32'd11);
      check("imul_b_lo", 32'(ResultLo), 32'h00FE);
      check("imul_b_hi", 32'(ResultHi), 32'h00FF);
      check("imul_b_flags", {29'b0, F_Carry, F_Overflow, F_DivError}, 32'b000);
      @(posedge CLK); #1;

      // MUL byte: upper operand bits ignored, 0x10 * 0x10 = 0x0100
      runOp(2'b00, 1'b0, 16'hAB10, 16'h7777, 16'hCD10, lat);
      check("mul_b_res", {ResultHi, ResultLo}, 32'h0001_0000);
      check("mul_b_flags", {29'b0, F_Carry, F_Overflow, F_DivError}, 32'b110);
      @(posedge CLK); #1;

      // MUL word max * max
      runOp(2'b00, 1'b1, 16'hFFFF, 16'h0000, 16'hFFFF, lat);
      check("mul_max_res", {ResultHi, ResultLo}, 32'hFFFE_0001);
      @(posedge CLK); #1;

      // IMUL word -1 * -1 = 1, no overflow
      runOp(2'b01, 1'b1, 16'hFFFF, 16'h0000, 16'hFFFF, lat);
      check("imul_neg_res", {ResultHi, ResultLo}, 32'h0000_0001);
      check("imul_neg_flags", {29'b0, F_Carry, F_Overflow, F_DivError}, 32'b000);
      @(posedge CLK); #1;

      // IMUL word 256 * 256 = 65536 does not fit signed 16 bits
      runOp(2'b01, 1'b1, 16'h0100, 16'h0000, 16'h0100, lat);
      check("imul_ovf_res", {ResultHi, ResultLo}, 32'h0001_0000);
      check("imul_ovf_flags", {29'b0, F_Carry, F_Overflow, F_DivError}, 32'b110);
      @(posedge CLK); #1;

      // DIV word 0x10000 / 3
      runOp(2'b10, 1'b1, 16'h0000, 16'h0001, 16'h0003, lat);
      check("div_w_lat", 32'(lat), 32'd19);
      check("div_w_lo", 32'(ResultLo), 32'h5555);
      check("div_w_hi", 32'(ResultHi), 32'h0001);
      check("div_w_flags", {29'b0, F_Carry, F_Overflow, F_DivError}, 32'b000);
      @(posedge CLK); #1;

      // DIV word by zero
      runOp(2'b10, 1'b1, 16'h1234, 16'h0000, 16'h0000, lat);
      check("div0_lat", 32'(lat), 32'd2);
      check("div0_flags", {29'b0, F_Carry, F_Overflow, F_DivError}, 32'b001);
      check("div0_res", {ResultHi, ResultLo}, 32'h0001_5555);
      @(posedge CLK); #1;

      // DIV byte quotient overflow: 0x0200 / 2
      runOp(2'b10, 1'b0, 16'h0000, 16'h0002, 16'h0002, lat);
      check("divovf_lat", 32'(lat), 32'd2);
      check("divovf_flags", {29'b0, F_Carry, F_Overflow, F_DivError}, 32'b001);
      check("divovf_res", {ResultHi, ResultLo}, 32'h0001_5555);
      @(posedge CLK); #1;

      // IDIV byte -7 / 2
      runOp(2'b11, 1'b0, 16'h00F9, 16'h00FF, 16'h0002, lat);
`ifdef ALU_MULDIV_IDIV_EN
      check("idiv_lat", 32'(lat), 32'd11);
      check("idiv_res", {ResultHi, ResultLo}, 32'h00FF_00FD);
      check("idiv_flags", {29'b0, F_Carry, F_Overflow, F_DivError}, 32'b000);
`else
      check("idiv_lat", 32'(lat), 32'd2);
      check("idiv_res", {ResultHi, ResultLo}, 32'h0001_5555);
      check("idiv_flags", {29'b0, F_Carry, F_Overflow, F_DivError}, 32'b001);
`endif
      @(posedge CLK); #1;

      // Second start while busy is ignored: exactly one done, at edge 19
      Operation = 2'b00; byteWord = 1'b1; A = 16'h0003; B = 16'h0005; start = 1'b1;
      @(posedge CLK); #1;
      start = 1'b0;
      @(posedge CLK); #1;
      check("busy_e1", 32'(busy), 32'h1);
      repeat (3) @(posedge CLK);
      #1;
      Operation = 2'b10; A = 16'h0009; B = 16'h0007; start = 1'b1;
      @(posedge CLK); #1;
      start = 1'b0;
      pulses = 0; lat = 0;
      for (int k = 6; k <= 45; k++) begin
         @(posedge CLK); #1;
         if (done) begin
            pulses++;
            if (lat == 0) lat = k;
         end
      end
      check("busy_pulses", 32'(pulses), 32'd1);
      check("busy_lat", 32'(lat), 32'd19);
      check("busy_res", {ResultHi, ResultLo}, 32'h0000_000F);

      // Reset at edge 5 of a MUL: outputs clear at once, no done follows
      Operation = 2'b00; byteWord = 1'b1; A = 16'h00FF; B = 16'h00FF; start = 1'b1;
      @(posedge CLK); #1;
      start = 1'b0;
      repeat (5) @(posedge CLK);
      #1;
      RESET_n = 1'b0;
      #1;
      check("rst_mid_res", {ResultHi, ResultLo}, 32'h0);
      check("rst_mid_status", {27'b0, busy, done, F_Carry, F_Overflow, F_DivError}, 32'h0);
      @(negedge CLK); RESET_n = 1'b1;
      pulses = 0;
      for (int k = 0; k < 30; k++) begin
         @(posedge CLK); #1;
         if (done) pulses++;
      end
      check("rst_no_done", 32'(pulses), 32'd0);

      // First start after reset is accepted: DIV byte 100 / 7
      runOp(2'b10, 1'b0, 16'h0064, 16'h0000, 16'h0007, lat);
      check("post_rst_lat", 32'(lat), 32'd11);
      check("post_rst_res", {ResultHi, ResultLo}, 32'h0002_000E);
      @(posedge CLK); #1;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
